// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: data-memory req/ack handshake, store lane alignment,
// load extraction and the registered register-file write port.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] alures_EX,
  input  logic [31:0] rdata2_EX,
  input  logic [31:0] immext_EX,
  input  logic [31:0] pcimm_EX,
  input  logic [31:0] pcnext_EX,
  input  logic [4:0]  rd_EX,
  input  logic        regwrite_EX,
  input  logic        datawe_EX,
  input  logic [2:0]  wbsel_EX,
  input  logic [2:0]  strb_EX,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        regwrite_WB,
  output logic [4:0]  rd_WB,
  output logic [31:0] wdata_WB,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The first request cycle is spent in IDLE, so WAIT aborts one count early.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 2);

  typedef enum logic {StIdle, StWait} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  logic        r_regwrite, r_misalign, r_timeout;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;

  logic        w_memop, w_misalign, w_aligned, w_req, w_tmo_abort, w_bubble;
  logic [3:0]  w_be;
  logic [31:0] w_store_data, w_load, w_wb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_memop = datawe_EX | (wbsel_EX == 3'b001);

  always_comb begin
    w_misalign = 1'b0;
    case (strb_EX)
      3'b001, 3'b100, 3'b111: w_misalign = alures_EX[0];
      3'b010, 3'b101:         w_misalign = |alures_EX[1:0];
      default:                w_misalign = 1'b0;
    endcase
  end

  assign w_aligned   = w_memop & ~w_misalign;
  assign w_req       = w_aligned | (r_state == StWait);
  assign w_tmo_abort = (r_state == StWait) & ~dmem_ack & (r_cnt == CntLast);
  assign w_bubble    = w_tmo_abort | (w_memop & w_misalign);
  assign mem_stall   = w_req & ~dmem_ack & ~w_tmo_abort;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_aligned && !dmem_ack) begin
          w_state_nxt = StWait;
          w_cnt_nxt   = '0;
        end
      end
      StWait: begin
        if (dmem_ack || w_tmo_abort) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_be         = 4'b1111;
    w_store_data = rdata2_EX;
    if (datawe_EX) begin
      case (strb_EX)
        3'b000: begin
          w_be         = 4'b0001 << alures_EX[1:0];
          w_store_data = {4{rdata2_EX[7:0]}};
        end
        3'b001: begin
          w_be         = 4'b0011 << {alures_EX[1], 1'b0};
          w_store_data = {2{rdata2_EX[15:0]}};
        end
        default: begin
          w_be         = 4'b1111;
          w_store_data = rdata2_EX;
        end
      endcase
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = w_req & datawe_EX;
  assign dmem_addr  = w_req ? {alures_EX[31:2], 2'b00} : 32'h0;
  assign dmem_be    = w_req ? w_be : 4'h0;
  assign dmem_wdata = (w_req & datawe_EX) ? w_store_data : 32'h0;

  always_comb begin
    case (alures_EX[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = alures_EX[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (strb_EX)
      3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {{16{w_half[15]}}, w_half};
      3'b110:  w_load = {24'h0, w_byte};
      3'b111:  w_load = {16'h0, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_comb begin
    case (wbsel_EX)
      3'b000:  w_wb = alures_EX;
      3'b001:  w_wb = w_load;
      3'b010:  w_wb = immext_EX;
      3'b011:  w_wb = pcimm_EX;
      3'b100:  w_wb = pcnext_EX;
      default: w_wb = 32'h0;
    endcase
  end

  // Stalls and aborted/misaligned accesses retire as bubbles; rd/wdata keep their old values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_misalign <= w_memop & w_misalign & (r_state == StIdle);
      if (w_tmo_abort) begin
        r_timeout <= 1'b1;
      end
      if (mem_stall || w_bubble) begin
        r_regwrite <= 1'b0;
      end else begin
        r_regwrite <= regwrite_EX & (rd_EX != 5'd0);
        r_rd       <= rd_EX;
        r_wdata    <= w_wb;
      end
    end
  end

  assign regwrite_WB  = r_regwrite;
  assign rd_WB        = r_rd;
  assign wdata_WB     = r_wdata;
  assign misalign_err = r_misalign;
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: transaction-level model of each instruction's cycles and WB result,
// checked every cycle, plus directed literal checks.
module tb_mem_wb_stage;
  localparam int unsigned TMO = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [31:0] alures_EX, rdata2_EX, immext_EX, pcimm_EX, pcnext_EX, dmem_rdata;
  logic [4:0]  rd_EX;
  logic        regwrite_EX, datawe_EX, dmem_ack;
  logic [2:0]  wbsel_EX, strb_EX;
  logic        dmem_req, dmem_we, mem_stall, regwrite_WB, misalign_err, timeout_err;
  logic [31:0] dmem_addr, dmem_wdata, wdata_WB;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_WB;

  mem_wb_stage #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .alures_EX(alures_EX), .rdata2_EX(rdata2_EX), .immext_EX(immext_EX),
    .pcimm_EX(pcimm_EX), .pcnext_EX(pcnext_EX), .rd_EX(rd_EX),
    .regwrite_EX(regwrite_EX), .datawe_EX(datawe_EX), .wbsel_EX(wbsel_EX), .strb_EX(strb_EX),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .regwrite_WB(regwrite_WB), .rd_WB(rd_WB), .wdata_WB(wdata_WB),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle, and the retirement it causes at the next edge.
  logic        c_req, c_we, c_stall, c_mis, c_tmo, c_rw;
  logic [1:0]  c_ret;  // 0 stall, 1 write, 2 bubble
  logic [31:0] c_addr, c_wd, c_wbv;
  logic [3:0]  c_be;
  logic [4:0]  c_rd;

  logic        m_rw, m_mis, m_tmo;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  // Pending instruction fields
  logic [31:0] f_alu, f_d2, f_imm, f_pci, f_pcn;
  logic [4:0]  f_rd;
  logic        f_rw, f_we;
  logic [2:0]  f_sel, f_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misal(input logic [2:0] strb, input logic [31:0] a);
    logic half, word;
    half = (strb == 3'd1) || (strb == 3'd4) || (strb == 3'd7);
    word = (strb == 3'd2) || (strb == 3'd5);
    return (half && a[0]) || (word && (a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] strb, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = rd >> (8 * a[1:0]);
    h = rd >> (16 * a[1]);
    case (strb)
      3'd3:    return 32'($signed(b[7:0]));
      3'd4:    return 32'($signed(h[15:0]));
      3'd6:    return {24'h0, b[7:0]};
      3'd7:    return {16'h0, h[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] wb_val(input logic [31:0] rdat);
    case (f_sel)
      3'd0:    return f_alu;
      3'd1:    return load_val(f_strb, f_alu, rdat);
      3'd2:    return f_imm;
      3'd3:    return f_pci;
      3'd4:    return f_pcn;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_rw <= 1'b0; m_rd <= '0; m_wd <= '0; m_mis <= 1'b0; m_tmo <= 1'b0;
    end else begin
      m_mis <= c_mis;
      if (c_tmo) m_tmo <= 1'b1;
      if (c_ret == 2'd1) begin
        m_rw <= c_rw; m_rd <= c_rd; m_wd <= c_wbv;
      end else begin
        m_rw <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmem_req", 32'(dmem_req), 32'(c_req));
      chk("mem_stall", 32'(mem_stall), 32'(c_stall));
      if (c_req) begin
        chk("dmem_addr", dmem_addr, c_addr);
        chk("dmem_we", 32'(dmem_we), 32'(c_we));
        chk("dmem_be", 32'(dmem_be), 32'(c_be));
        if (c_we) chk("dmem_wdata", dmem_wdata, c_wd);
      end
      chk("regwrite_WB", 32'(regwrite_WB), 32'(m_rw));
      if (m_rw) begin
        chk("rd_WB", 32'(rd_WB), 32'(m_rd));
        chk("wdata_WB", wdata_WB, m_wd);
      end
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
      chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    end
  end

  task automatic set_nop();
    f_alu = 0; f_d2 = 0; f_imm = 0; f_pci = 0; f_pcn = 0; f_rd = 0;
    f_rw = 0; f_we = 0; f_sel = 0; f_strb = 0;
  endtask

  task automatic apply_fields();
    alures_EX = f_alu; rdata2_EX = f_d2; immext_EX = f_imm; pcimm_EX = f_pci;
    pcnext_EX = f_pcn; rd_EX = f_rd; regwrite_EX = f_rw; datawe_EX = f_we;
    wbsel_EX = f_sel; strb_EX = f_strb;
  endtask

  // Runs the pending instruction; lat is the request cycle index carrying ack (NEVER = none).
  task automatic do_instr(input int lat, input logic [31:0] rdat, input int max_cyc,
                          output int req_n, output int stall_n,
                          output logic [3:0] be0, output logic [31:0] wd0);
    logic memop, mis, aligned, last;
    int n;
    memop   = f_we || (f_sel == 3'd1);
    mis     = memop && misal(f_strb, f_alu);
    aligned = memop && !mis;
    n = aligned ? ((lat < int'(TMO)) ? lat + 1 : int'(TMO)) : 1;
    req_n = 0; stall_n = 0; be0 = '0; wd0 = '0;
    for (int i = 0; i < n && i < max_cyc; i++) begin
      @(posedge clk); #1;
      apply_fields();
      dmem_ack   = aligned ? (i == lat) : 1'($urandom_range(0, 1));
      dmem_rdata = (aligned && i == lat) ? rdat : $urandom;
      last    = (i == n - 1);
      c_req   = aligned;
      c_we    = aligned && f_we;
      c_addr  = {f_alu[31:2], 2'b00};
      c_be    = 4'hF;
      c_wd    = f_d2;
      if (f_we && f_strb == 3'd0) begin
        c_be = 4'(1 << f_alu[1:0]); c_wd = f_d2[7:0] * 32'h01010101;
      end else if (f_we && f_strb == 3'd1) begin
        c_be = 4'(3 << (2 * f_alu[1])); c_wd = f_d2[15:0] * 32'h00010001;
      end
      c_stall = aligned && !last;
      c_mis   = mis;
      c_tmo   = aligned && last && (lat >= int'(TMO));
      c_ret   = !last ? 2'd0 : (mis || c_tmo) ? 2'd2 : 2'd1;
      c_rw    = f_rw && (f_rd != 5'd0);
      c_rd    = f_rd;
      c_wbv   = wb_val(rdat);
      @(negedge clk);
      if (dmem_req) req_n++;
      if (mem_stall) stall_n++;
      if (i == 0) begin be0 = dmem_be; wd0 = dmem_wdata; end
    end
  endtask

  task automatic idle();
    int rn, sn;
    logic [3:0] b;
    logic [31:0] w;
    set_nop();
    do_instr(0, 32'h0, 1, rn, sn, b, w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rn, sn, r, lat;
    logic [3:0] b0;
    logic [31:0] w0;
    logic [2:0] lstrb [4] = '{3'd3, 3'd6, 3'd4, 3'd7};
    logic [31:0] laddr [4] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002};
    logic [31:0] lexp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};

    rstn = 1'b1; dmem_ack = 0; dmem_rdata = 0;
    set_nop(); apply_fields();
    c_req = 0; c_we = 0; c_stall = 0; c_mis = 0; c_tmo = 0; c_rw = 0; c_ret = 2'd1;
    c_addr = 0; c_wd = 0; c_wbv = 0; c_be = 0; c_rd = 0;
    #2 rstn = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_regwrite", 32'(regwrite_WB), 32'h0);
    chk("rst_wdata", wdata_WB, 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    @(posedge clk); #1 rstn = 1'b1;
    idle();

    // ADD passes straight through
    set_nop(); f_alu = 32'h12345678; f_rd = 5; f_rw = 1;
    do_instr(0, 0, NEVER, rn, sn, b0, w0);
    chk("add_stall_cycles", 32'(sn), 32'd0);
    idle();
    chk("add_regwrite", 32'(regwrite_WB), 32'd1);
    chk("add_rd", 32'(rd_WB), 32'd5);
    chk("add_wdata", wdata_WB, 32'h12345678);

    // SB with ack on the fourth request cycle
    set_nop(); f_alu = 32'h1003; f_d2 = 32'hAB; f_we = 1;
    do_instr(3, 0, NEVER, rn, sn, b0, w0);
    chk("sb_be", 32'(b0), 32'h8);
    chk("sb_wdata", w0, 32'hABABABAB);
    chk("sb_stall_cycles", 32'(sn), 32'd3);
    chk("sb_req_cycles", 32'(rn), 32'd4);
    idle();
    chk("sb_regwrite", 32'(regwrite_WB), 32'd0);

    for (int k = 0; k < 4; k++) begin
      set_nop(); f_alu = laddr[k]; f_sel = 1; f_strb = lstrb[k]; f_rd = 7; f_rw = 1;
      do_instr(0, 32'h80FF7F01, NEVER, rn, sn, b0, w0);
      chk("load_stall_cycles", 32'(sn), 32'd0);
      idle();
      chk("load_wdata", wdata_WB, lexp[k]);
    end

    // Misaligned LW
    set_nop(); f_alu = 32'h6; f_sel = 1; f_strb = 5; f_rd = 9; f_rw = 1;
    do_instr(0, 0, NEVER, rn, sn, b0, w0);
    chk("mis_req_cycles", 32'(rn), 32'd0);
    idle();
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    chk("mis_regwrite", 32'(regwrite_WB), 32'd0);
    idle();
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);

    // LW that never gets ack, then a normal LW
    set_nop(); f_alu = 32'h8; f_sel = 1; f_strb = 5; f_rd = 4; f_rw = 1;
    do_instr(NEVER, 0, NEVER, rn, sn, b0, w0);
    chk("tmo_req_cycles", 32'(rn), 32'd16);
    chk("tmo_stall_cycles", 32'(sn), 32'd15);
    idle();
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_regwrite", 32'(regwrite_WB), 32'd0);
    set_nop(); f_alu = 32'hC; f_sel = 1; f_strb = 5; f_rd = 3; f_rw = 1;
    do_instr(0, 32'hCAFEF00D, NEVER, rn, sn, b0, w0);
    idle();
    chk("after_tmo_wdata", wdata_WB, 32'hCAFEF00D);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a WAIT
    set_nop(); f_alu = 32'h10; f_sel = 1; f_strb = 5; f_rd = 6; f_rw = 1;
    do_instr(NEVER, 0, 3, rn, sn, b0, w0);
    @(posedge clk); #1;
    rstn = 1'b0; dmem_ack = 0; set_nop(); apply_fields();
    c_req = 0; c_we = 0; c_stall = 0; c_mis = 0; c_tmo = 0; c_rw = 0; c_ret = 2'd1;
    @(negedge clk);
    chk("rstw_req", 32'(dmem_req), 32'd0);
    chk("rstw_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; dmem_ack = 1;
    @(negedge clk);
    chk("rstw_ack_ignored", 32'(dmem_req), 32'd0);
    idle();
    chk("rstw_regwrite", 32'(regwrite_WB), 32'd0);

    for (int t = 0; t < 300; t++) begin
      set_nop();
      f_alu = $urandom; f_d2 = $urandom; f_imm = $urandom; f_pci = $urandom; f_pcn = $urandom;
      f_rd = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 2);
      if (r == 0) begin
        f_sel = 3'($urandom_range(0, 7));
        if (f_sel == 3'd1) f_sel = 3'd0;
        f_strb = 3'($urandom_range(0, 7)); f_rw = 1'($urandom_range(0, 3) != 0);
      end else if (r == 1) begin
        f_sel = 1; f_strb = 3'($urandom_range(3, 7)); f_rw = 1;
      end else begin
        f_we = 1; f_strb = 3'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) != 0) f_alu[1:0] = 2'b00;
      r = $urandom_range(0, 19);
      if (r < 10)       lat = $urandom_range(0, 3);
      else if (r < 16)  lat = $urandom_range(4, 14);
      else if (r < 19)  lat = int'(TMO) - 1;
      else              lat = NEVER;
      do_instr(lat, $urandom, NEVER, rn, sn, b0, w0);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
